// File: rtl/game_pkg.sv
//------------------------------------------------------------------------------
// Module  : game_pkg
// Brief   : Shared types and constants for the game timer slice.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package game_pkg;

    typedef logic [1:0][3:0] bcd2_t;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } timer_state_t;

    localparam bcd2_t BCD_MAX = {4'd9, 4'd9};

    // Binary value (0..99) of a well-formed two-digit BCD number.
    function automatic logic [6:0] bcd2_to_int(bcd2_t v);
        return ({3'b000, v[1]} * 7'd10) + {3'b000, v[0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd2_add_sat.sv
//------------------------------------------------------------------------------
// Module  : bcd2_add_sat
// Brief   : Combinational two-digit BCD adder; digits above 9 clamp to 9,
//           results above 99 saturate to 99.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bcd2_add_sat
    import game_pkg::*;
(
    input  logic [1:0][3:0] a,
    input  logic [1:0][3:0] b,
    output logic [1:0][3:0] sum
);

    logic [3:0] a1, a0, b1, b0;
    logic [4:0] ones_raw;
    logic [4:0] tens_raw;
    logic       carry;
    logic [3:0] ones;

    always_comb begin
        a1 = (a[1] > 4'd9) ? 4'd9 : a[1];
        a0 = (a[0] > 4'd9) ? 4'd9 : a[0];
        b1 = (b[1] > 4'd9) ? 4'd9 : b[1];
        b0 = (b[0] > 4'd9) ? 4'd9 : b[0];

        ones_raw = {1'b0, a0} + {1'b0, b0};
        carry    = (ones_raw > 5'd9);
        // Adding 6 modulo 16 is the same as subtracting 10 for 10..18.
        ones     = carry ? (ones_raw[3:0] + 4'd6) : ones_raw[3:0];
        tens_raw = {1'b0, a1} + {1'b0, b1} + {4'b0000, carry};

        if (tens_raw > 5'd9) begin
            sum = BCD_MAX;
        end else begin
            sum = {tens_raw[3:0], ones};
        end
    end

endmodule

`default_nettype wire

// File: rtl/game_timer.sv
//------------------------------------------------------------------------------
// Module  : game_timer
// Brief   : Two-digit BCD level countdown timer driven by frame ticks.
//           Optional low-time blink output enabled by macro TIMER_WARN_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module game_timer
    import game_pkg::*;
#(
    parameter int FRAMES_PER_SEC = 30
`ifdef TIMER_WARN_EN
    ,
    parameter int WARN_SECS      = 10,
    parameter int BLINK_FRAMES   = 8
`endif
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic            startOfFrame,
    input  logic            add_time,
    input  logic [1:0][3:0] time_to_add,
    input  logic            player_active,
    output logic [1:0][3:0] time_digits,
    output logic            out_of_time,
    output logic            timer_running,
    output logic            low_time_blink
);

    localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_SEC - 1);

    timer_state_t state_q, state_d;
    bcd2_t        digits_q, digits_d;
    logic [7:0]   frame_cnt_q, frame_cnt_d;
    logic         out_of_time_q, out_of_time_d;

    logic         dec;
    logic [7:0]   frame_cnt_run;
    bcd2_t        dec_val;
    bcd2_t        add_b;
    bcd2_t        sum;

    // Frame counting and the inline decrement, which is applied before the add.
    always_comb begin
        dec           = 1'b0;
        frame_cnt_run = frame_cnt_q;
        if (state_q == RUN && startOfFrame && player_active) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_run = 8'd0;
                dec           = (digits_q != '0);
            end else begin
                frame_cnt_run = frame_cnt_q + 8'd1;
            end
        end

        dec_val = digits_q;
        if (dec) begin
            if (digits_q[0] == 4'd0) begin
                dec_val[0] = 4'd9;
                dec_val[1] = digits_q[1] - 4'd1;
            end else begin
                dec_val[0] = digits_q[0] - 4'd1;
            end
        end

        add_b = add_time ? time_to_add : '0;
    end

    bcd2_add_sat u_add (
        .a   (dec_val),
        .b   (add_b),
        .sum (sum)
    );

    always_comb begin
        state_d     = state_q;
        digits_d    = digits_q;
        frame_cnt_d = frame_cnt_run;

        case (state_q)
            LOAD: begin
                if (add_time) begin
                    digits_d    = sum;
                    state_d     = RUN;
                    frame_cnt_d = 8'd0;
                end
            end
            RUN: begin
                digits_d = sum;
                if (dec && sum == '0) begin
                    state_d = EXPIRED;
                end
            end
            EXPIRED: begin
                digits_d = '0;
            end
            default: begin
                state_d  = LOAD;
                digits_d = '0;
            end
        endcase

        out_of_time_d = (state_d == EXPIRED);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= LOAD;
            digits_q      <= '0;
            frame_cnt_q   <= 8'd0;
            out_of_time_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            digits_q      <= digits_d;
            frame_cnt_q   <= frame_cnt_d;
            out_of_time_q <= out_of_time_d;
        end
    end

    assign time_digits   = digits_q;
    assign out_of_time   = out_of_time_q;
    assign timer_running = (state_q == RUN) && player_active;

`ifdef TIMER_WARN_EN
    localparam logic [6:0] WARN_VAL   = 7'(WARN_SECS);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic       warn_q, warn_d;
    logic       blink_q, blink_d;
    logic [7:0] blink_cnt_q, blink_cnt_d;

    // Zone is judged on the next digits so the blink lines up with the display.
    always_comb begin
        warn_d      = warn_q;
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        if (state_d != RUN || bcd2_to_int(digits_d) > WARN_VAL) begin
            warn_d      = 1'b0;
            blink_d     = 1'b0;
            blink_cnt_d = 8'd0;
        end else if (!warn_q) begin
            warn_d      = 1'b1;
            blink_d     = 1'b1;
            blink_cnt_d = 8'd0;
        end else if (startOfFrame) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = 8'd0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            warn_q      <= 1'b0;
            blink_q     <= 1'b0;
            blink_cnt_q <= 8'd0;
        end else begin
            warn_q      <= warn_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign low_time_blink = blink_q;
`else
    assign low_time_blink = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_game_timer.sv
//------------------------------------------------------------------------------
// Module  : tb_game_timer
// Brief   : Randomized scoreboard bench for game_timer against an integer
//           seconds/frames reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_game_timer;
    import game_pkg::*;

    localparam int F    = 30;
    localparam int WARN = 10;
    localparam int BF   = 8;

    logic            clk = 1'b0;
    logic            resetN = 1'b0;
    logic            sof = 1'b0;
    logic            add_time = 1'b0;
    logic [1:0][3:0] tta = '0;
    logic            pa = 1'b0;
    logic [1:0][3:0] digits;
    logic            oot, running, blink;

    always #5 clk = ~clk;

    game_timer dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (sof),
        .add_time       (add_time),
        .time_to_add    (tta),
        .player_active  (pa),
        .time_digits    (digits),
        .out_of_time    (oot),
        .timer_running  (running),
        .low_time_blink (blink)
    );

    typedef struct {
        logic [7:0] digits;
        bit         oot;
        bit         run;
        bit         blink;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: phase 0=waiting for load, 1=counting, 2=expired.
    int m_phase, m_rem, m_fc, m_bc;
    bit m_blink, m_warn;

    function automatic void model_reset();
        m_phase = 0; m_rem = 0; m_fc = 0; m_bc = 0;
        m_blink = 0; m_warn = 0;
    endfunction

    function automatic void model_step(bit s, bit a, logic [7:0] ad, bit p);
        int t, o, addv, r;
        bit d;
        t    = (ad[7:4] > 9) ? 9 : int'(ad[7:4]);
        o    = (ad[3:0] > 9) ? 9 : int'(ad[3:0]);
        addv = a ? (10 * t + o) : 0;
        if (m_phase == 0) begin
            if (a) begin
                m_rem   = (addv > 99) ? 99 : addv;
                m_phase = 1;
                m_fc    = 0;
            end
        end else if (m_phase == 1) begin
            d = 0;
            if (p && s) begin
                if (m_fc == F - 1) begin
                    m_fc = 0;
                    d    = (m_rem > 0);
                end else begin
                    m_fc++;
                end
            end
            r = m_rem - (d ? 1 : 0) + addv;
            if (r > 99) r = 99;
            if (d && r == 0) m_phase = 2;
            m_rem = r;
        end
`ifdef TIMER_WARN_EN
        if (!(m_phase == 1 && m_rem <= WARN)) begin
            m_blink = 0; m_bc = 0; m_warn = 0;
        end else if (!m_warn) begin
            m_warn = 1; m_blink = 1; m_bc = 0;
        end else if (s) begin
            m_bc++;
            if (m_bc == BF) begin
                m_bc    = 0;
                m_blink = !m_blink;
            end
        end
`endif
    endfunction

    function automatic logic [7:0] to_bcd(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic void check(string name, int act, int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
        end
    endfunction

    // Monitor: one expected record per clock edge following a driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("time_digits",    int'(digits),  int'(e.digits));
                check("out_of_time",    int'(oot),     int'(e.oot));
                check("timer_running",  int'(running), int'(e.run));
                check("low_time_blink", int'(blink),   int'(e.blink));
            end
        end
    end

    task automatic cyc(bit s, bit a, logic [7:0] ad, bit p);
        exp_t e;
        @(negedge clk);
        sof = s; add_time = a; tta = ad; pa = p;
        model_step(s, a, ad, p);
        e.digits = to_bcd(m_rem);
        e.oot    = (m_phase == 2);
        e.run    = (m_phase == 1) && p;
        e.blink  = m_blink;
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        sof = 0; add_time = 0; tta = '0; pa = 0;
        resetN = 0;
        model_reset();
        #1;
        check("rst_digits",  int'(digits),  0);
        check("rst_oot",     int'(oot),     0);
        check("rst_running", int'(running), 0);
        check("rst_blink",   int'(blink),   0);
        @(negedge clk);
        resetN = 1;
    endtask

    task automatic rand_run(int n, int add_mod);
        for (int i = 0; i < n; i++) begin
            cyc(1'($urandom % 2), ($urandom % add_mod) == 0, 8'($urandom),
                ($urandom % 10) != 0);
        end
    endtask

    initial begin
        model_reset();
        #2;
        check("rst_digits",  int'(digits),  0);
        check("rst_oot",     int'(oot),     0);
        check("rst_running", int'(running), 0);
        check("rst_blink",   int'(blink),   0);
        @(negedge clk);
        resetN = 1;

        // Idle in LOAD with frames: no countdown, no expiry.
        for (int i = 0; i < 40; i++) cyc(1, 0, 8'h00, 1);
        cyc(0, 1, 8'h99, 1);
        for (int i = 0; i < 660; i++) cyc(1, 0, 8'h00, 1);
        rand_run(1500, 100);

        // 01 at the last frame of a second with a simultaneous add of 10.
        do_reset();
        cyc(0, 1, 8'h01, 1);
        for (int i = 0; i < 200 && m_fc != F - 1; i++) cyc(1, 0, 8'h00, 1);
        cyc(1, 1, 8'h10, 1);
        for (int i = 0; i < 400 && m_phase == 1; i++) cyc(1, 0, 8'h00, 1);
        for (int i = 0; i < 100; i++) cyc(1, 1'($urandom % 2), 8'($urandom), 1);

        // Saturation and digit clamping.
        do_reset();
        cyc(0, 1, 8'h95, 1);
        cyc(0, 1, 8'h10, 1);
        do_reset();
        cyc(0, 1, 8'h50, 1);
        cyc(0, 1, 8'hC3, 1);
        do_reset();
        cyc(0, 1, 8'h00, 1);
        for (int i = 0; i < 70; i++) cyc(1, 0, 8'h00, 1);

        // Freeze at 42 then resume.
        do_reset();
        cyc(0, 1, 8'h42, 1);
        for (int i = 0; i < 17; i++) cyc(1, 0, 8'h00, 1);
        for (int i = 0; i < 90; i++) cyc(1, 0, 8'h00, 0);
        for (int i = 0; i < 60; i++) cyc(1, 0, 8'h00, 1);

        // Randomized episodes from low starting times, including expiry.
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            cyc(0, 1, {4'($urandom % 2), 4'($urandom % 10)}, 1);
            rand_run(1500, 300);
        end

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
